press_decoder: RTL and testbench



---
 rtl/press_pkg.sv | 22 ++
 rtl/tick_prescaler.sv | 41 ++++
 rtl/press_decoder.sv | 128 ++++++++++++
 tb/tb_press_decoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/press_pkg.sv
// Shared definitions for the pushbutton press decoder and its tick prescaler:
// FSM state encoding, default 50 MHz timing constants and a small helper.
package press_pkg;

    // Default timing for a 50 MHz board clock
    localparam int unsigned DEF_TICK_DIV   = 500000;   // 10 ms tick
    localparam int unsigned DEF_LONG_TICKS = 100;      // 1 s hold
    localparam int unsigned DEF_GAP_TICKS  = 30;       // 300 ms double window

    // FSM state encoding
    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [ST_W-1:0] ST_PRESS1 = 2'd1;
    localparam logic [ST_W-1:0] ST_GAP    = 2'd2;
    localparam logic [ST_W-1:0] ST_HOLD   = 2'd3;

    // Larger of two elaboration-time constants
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
// Ports:
//   clk_50MHZ  in  system clock
//   reset      in  synchronous, active-high
//   tick       out one-cycle pulse while the counter sits at terminal count
module tick_prescaler
    import press_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk_50MHZ,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Wrap at terminal count; tick is registered from the next count so it
    // is high exactly while cnt_q == CNT_LAST
    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        tick_d = (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk_50MHZ) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/press_decoder.sv
// Classifies a debounced button level into single, double and long press
// events, each a registered one-cycle pulse. Durations are counted in
// prescaled ticks.
// Ports:
//   clk_50MHZ     in  system clock
//   reset         in  synchronous, active-high
//   btn_level     in  debounced button, 1 = pressed, synchronous to clk
//   single_press  out pulse: short press with no second press in the window
//   double_press  out pulse: second press inside the gap window
//   long_press    out pulse: button held LONG_TICKS
//   busy          out registered "state is not IDLE"
module press_decoder
    import press_pkg::*;
#(
    parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
    parameter int unsigned LONG_TICKS = DEF_LONG_TICKS,
    parameter int unsigned GAP_TICKS  = DEF_GAP_TICKS
) (
    input  logic clk_50MHZ,
    input  logic reset,
    input  logic btn_level,
    output logic single_press,
    output logic double_press,
    output logic long_press,
    output logic busy
);

    localparam int unsigned TMAX   = max_u(LONG_TICKS, GAP_TICKS);
    localparam int unsigned TCNT_W = $clog2(TMAX + 1);
    localparam logic [TCNT_W-1:0] TCNT_SAT  = TCNT_W'(TMAX);
    localparam logic [TCNT_W-1:0] LONG_LAST = TCNT_W'(LONG_TICKS - 1);
    localparam logic [TCNT_W-1:0] GAP_LAST  = TCNT_W'(GAP_TICKS - 1);

    logic              tick;
    logic              btn_q;
    logic              rise_c, fall_c;
    logic [ST_W-1:0]   state_q, state_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              single_q, single_d;
    logic              double_q, double_d;
    logic              long_q, long_d;
    logic              busy_q, busy_d;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk_50MHZ (clk_50MHZ),
        .reset     (reset),
        .tick      (tick)
    );

    // Edge detect against the previous level
    assign rise_c = btn_level & ~btn_q;
    assign fall_c = ~btn_level & btn_q;

    // Next state and event decode; button edges take priority over the
    // tick that would complete a timeout in the same cycle
    always_comb begin
        state_d  = state_q;
        single_d = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise_c) state_d = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (fall_c) begin
                    state_d = ST_GAP;
                end else if (tick && (tcnt_q == LONG_LAST)) begin
                    state_d = ST_HOLD;
                    long_d  = 1'b1;
                end
            end
            ST_GAP: begin
                if (rise_c) begin
                    state_d  = ST_HOLD;
                    double_d = 1'b1;
                end else if (tick && (tcnt_q == GAP_LAST)) begin
                    state_d  = ST_IDLE;
                    single_d = 1'b1;
                end
            end
            default: begin
                // HOLD: wait out the release, no events
                if (fall_c) state_d = ST_IDLE;
            end
        endcase
    end

    // Tick counter restarts on every state change and saturates
    always_comb begin
        tcnt_d = tcnt_q;
        if (state_d != state_q) begin
            tcnt_d = '0;
        end else if (tick && (tcnt_q != TCNT_SAT)) begin
            tcnt_d = tcnt_q + TCNT_W'(1);
        end
        busy_d = (state_q != ST_IDLE);
    end

    // btn_q resets high so a button held through reset gives no rise
    always_ff @(posedge clk_50MHZ) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            btn_q    <= 1'b1;
            tcnt_q   <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            btn_q    <= btn_level;
            tcnt_q   <= tcnt_d;
            single_q <= single_d;
            double_q <= double_d;
            long_q   <= long_d;
            busy_q   <= busy_d;
        end
    end

    assign single_press = single_q;
    assign double_press = double_q;
    assign long_press   = long_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_press_decoder.sv
// Bench for press_decoder with TICK_DIV=4, LONG_TICKS=5, GAP_TICKS=3.
// Gestures come from a vector table plus hand-written corner sequences;
// expected pulses are queued with their allowed cycle window and matched by
// a monitor on the falling clock edge.
module tb_press_decoder;

    localparam int K_NONE   = 0;
    localparam int K_SINGLE = 1;
    localparam int K_DOUBLE = 2;
    localparam int K_LONG   = 3;

    // Reference point for a vector's expected window
    localparam int R_RISE1 = 0;
    localparam int R_REL1  = 1;
    localparam int R_RISE2 = 2;

    typedef struct {
        string name;
        int    press1;
        int    gap;      // 0 = no second press
        int    press2;
        int    kind;
        int    ref_pt;
        int    lo;
        int    hi;
    } vec_t;

    typedef struct {
        int kind;
        int lo;
        int hi;
    } exp_t;

    logic clk_50MHZ = 1'b0;
    logic reset     = 1'b1;
    logic btn_level = 1'b0;
    logic single_press, double_press, long_press, busy;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   last_kind = 0;
    int   busy_seen = 0;
    exp_t sb_q[$];
    vec_t vecs[8];

    press_decoder #(
        .TICK_DIV   (4),
        .LONG_TICKS (5),
        .GAP_TICKS  (3)
    ) dut (
        .clk_50MHZ    (clk_50MHZ),
        .reset        (reset),
        .btn_level    (btn_level),
        .single_press (single_press),
        .double_press (double_press),
        .long_press   (long_press),
        .busy         (busy)
    );

    always #5 clk_50MHZ = ~clk_50MHZ;

    always @(posedge clk_50MHZ) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp_v);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    endtask

    task automatic chk_win(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got cycle %0d, expected cycle %0d..%0d", name, act, lo, hi);
    endtask

    task automatic step();
        @(posedge clk_50MHZ);
        #1;
    endtask

    task automatic push(input int kind, input int lo, input int hi);
        exp_t e;
        e.kind = kind;
        e.lo   = lo;
        e.hi   = hi;
        sb_q.push_back(e);
    endtask

    // Pulse monitor: every pulse must match the head of the scoreboard
    always @(negedge clk_50MHZ) begin
        int   k;
        int   np;
        exp_t e;
        np = int'(single_press) + int'(double_press) + int'(long_press);
        k  = single_press ? K_SINGLE : double_press ? K_DOUBLE : long_press ? K_LONG : K_NONE;
        if (busy) busy_seen = 1;
        if (last_kind == K_SINGLE) chk(busy == 1'b0, "busy_falls_after_single", int'(busy), 0);
        if (np > 0) begin
            chk(np == 1, "pulse_onehot", np, 1);
            chk(busy == 1'b1, "busy_during_pulse", int'(busy), 1);
            if (sb_q.size() == 0) begin
                chk(1'b0, "unexpected_pulse", k, K_NONE);
            end else begin
                e = sb_q.pop_front();
                chk(k == e.kind, "pulse_kind", k, e.kind);
                chk_win("pulse_time", cyc, e.lo, e.hi);
            end
        end
        last_kind = k;
    end

    task automatic end_scenario(input string name);
        chk(sb_q.size() == 0, {name, "_missing_pulse"}, sb_q.size(), 0);
        chk(busy == 1'b0, {name, "_idle_at_end"}, int'(busy), 0);
        sb_q.delete();
    endtask

    task automatic run_vec(input vec_t v);
        btn_level = 1'b1;
        if (v.ref_pt == R_RISE1) push(v.kind, cyc + v.lo, cyc + v.hi);
        repeat (v.press1) step();
        btn_level = 1'b0;
        if (v.ref_pt == R_REL1) push(v.kind, cyc + v.lo, cyc + v.hi);
        if (v.gap > 0) begin
            repeat (v.gap) step();
            btn_level = 1'b1;
            if (v.ref_pt == R_RISE2) push(v.kind, cyc + v.lo, cyc + v.hi);
            repeat (v.press2) step();
            btn_level = 1'b0;
        end
        repeat (25) step();
        end_scenario(v.name);
    endtask

    // One-edge reset; returns with cyc equal to the edge that sampled it
    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int r;

        // Offsets count edges from the edge before the driven change.
        // Release: GAP entered next edge, 3 ticks of period 4 -> +10..+13.
        // Press: PRESS1 entered next edge, 5 ticks -> +18..+21.
        // Double: decided in the cycle of the second rise -> +1.
        vecs[0] = '{"single_p8",   8, 0,  0, K_SINGLE, R_REL1,  10, 13};
        vecs[1] = '{"single_p1",   1, 0,  0, K_SINGLE, R_REL1,  10, 13};
        vecs[2] = '{"single_p12", 12, 0,  0, K_SINGLE, R_REL1,  10, 13};
        vecs[3] = '{"double_long_hold", 6, 4, 40, K_DOUBLE, R_RISE2, 1, 1};
        vecs[4] = '{"double_gap1", 3, 1,  5, K_DOUBLE, R_RISE2,  1,  1};
        vecs[5] = '{"double_gap_edge", 4, 9, 10, K_DOUBLE, R_RISE2, 1, 1};
        vecs[6] = '{"long_40",    40, 0,  0, K_LONG,   R_RISE1, 18, 21};
        vecs[7] = '{"long_25",    25, 0,  0, K_LONG,   R_RISE1, 18, 21};

        // Reset state
        repeat (3) step();
        chk(single_press == 1'b0, "reset_single", int'(single_press), 0);
        chk(double_press == 1'b0, "reset_double", int'(double_press), 0);
        chk(long_press == 1'b0, "reset_long", int'(long_press), 0);
        chk(busy == 1'b0, "reset_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (4) step();
        chk(busy == 1'b0, "idle_after_reset", int'(busy), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Triple press: one double, then the third press is a fresh single
        btn_level = 1'b1;
        repeat (3) step();
        btn_level = 1'b0;
        repeat (3) step();
        btn_level = 1'b1;
        push(K_DOUBLE, cyc + 1, cyc + 1);
        repeat (3) step();
        btn_level = 1'b0;
        repeat (3) step();
        btn_level = 1'b1;
        repeat (3) step();
        btn_level = 1'b0;
        push(K_SINGLE, cyc + 10, cyc + 13);
        repeat (25) step();
        end_scenario("triple");

        // Reset during GAP: everything clears, no single follows
        btn_level = 1'b1;
        repeat (4) step();
        btn_level = 1'b0;
        repeat (3) step();
        chk(busy == 1'b1, "busy_in_gap", int'(busy), 1);
        reset = 1'b1;
        step();
        chk(single_press == 1'b0, "midreset_single", int'(single_press), 0);
        chk(double_press == 1'b0, "midreset_double", int'(double_press), 0);
        chk(long_press == 1'b0, "midreset_long", int'(long_press), 0);
        chk(busy == 1'b0, "midreset_busy", int'(busy), 0);
        reset = 1'b0;
        busy_seen = 0;
        repeat (25) step();
        chk(busy_seen == 0, "midreset_stays_idle", busy_seen, 0);
        end_scenario("midreset");

        // Button held through reset release: no rise, release ignored
        btn_level = 1'b1;
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        busy_seen = 0;
        repeat (30) step();
        btn_level = 1'b0;
        repeat (20) step();
        chk(busy_seen == 0, "held_reset_stays_idle", busy_seen, 0);
        end_scenario("held_reset");

        // Release aligned with the tick completing LONG_TICKS.
        // After the reset edge R, ticks are sampled at R+4, R+8, ...
        // Rise sampled at R+4, fifth tick at R+24, three GAP ticks to R+36.
        do_reset();
        r = cyc;
        repeat (3) step();
        btn_level = 1'b1;
        repeat (20) step();
        btn_level = 1'b0;
        push(K_SINGLE, r + 36, r + 36);
        repeat (30) step();
        end_scenario("fall_beats_long");

        // Same alignment, release one cycle later: long at exactly R+24
        do_reset();
        r = cyc;
        push(K_LONG, r + 24, r + 24);
        repeat (3) step();
        btn_level = 1'b1;
        repeat (21) step();
        btn_level = 1'b0;
        repeat (20) step();
        end_scenario("long_exact");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
